// File: rtl/de2_115_sopc_sd_spi_if.sv
// Avalon-MM slave bus bundle for the SD-card SPI engine.
// The CPU side drives through the master modport, and the engine answers through the slave modport.
interface de2_115_sopc_sd_spi_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/de2_115_sopc_sd_spi.sv
// SD-card SPI-mode byte engine (mode 0, MSB first) behind an Avalon-MM slave port.
// The engine generates a programmable sd_clk, shifts a byte out on MOSI, and captures a byte from MISO.
module de2_115_sopc_sd_spi #(
  parameter int          DIV_W       = 8,
  parameter int unsigned DEFAULT_DIV = 124
) (
  input  logic                 clk,
  input  logic                 reset_n,
  de2_115_sopc_sd_spi_if.slave bus,
  output logic                 sd_clk,
  output logic                 sd_mosi,
  output logic                 sd_cs_n,
  input  logic                 sd_miso
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_DIV    = 2'd2;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_q, rx_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             cs_n_q, cs_n_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             miso_meta_q, miso_sync_q;

  logic             wr_en, rd_en;
  logic             data_wr, status_wr, div_wr, data_rd;
  logic             busy;
  logic [7:0]       rx_next;
  logic             unused_wdata;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign rd_en     = bus.chipselect && !bus.read_n;
  assign data_wr   = wr_en && (bus.address == A_DATA);
  assign status_wr = wr_en && (bus.address == A_STATUS);
  assign div_wr    = wr_en && (bus.address == A_DIV);
  assign data_rd   = rd_en && (bus.address == A_DATA);
  assign busy      = (state_q != ST_IDLE);
  assign rx_next   = {rx_sh_q[6:0], miso_sync_q};

  assign unused_wdata = ^bus.writedata[31:8];

  // MISO is asynchronous to clk. The two flops cost the 2-cycle sample latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso_meta_q <= 1'b1;
      miso_sync_q <= 1'b1;
    end else begin
      miso_meta_q <= sd_miso;
      miso_sync_q <= miso_meta_q;
    end
  end

  // NOTE: every *_d defaults to its *_q first, so no branch can leave a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done_d  = done_q;
    ovr_d   = ovr_q;

    if (div_wr) begin
      div_d = bus.writedata[DIV_W-1:0];
    end
    if (status_wr) begin
      cs_n_d = bus.writedata[2];
      if (bus.writedata[3]) ovr_d = 1'b0;
    end
    // A completion later in this block overrides this clear.
    if (data_rd) begin
      done_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (data_wr) begin
          tx_d    = bus.writedata[7:0];
          mosi_d  = bus.writedata[7];
          sclk_d  = 1'b0;
          cnt_d   = div_q;
          bit_d   = 3'd0;
          done_d  = 1'b0;
          state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        if (data_wr) ovr_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cnt_d   = div_q;
          sclk_d  = 1'b1;
          state_d = ST_HIGH;
        end
      end

      ST_HIGH: begin
        if (data_wr) ovr_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else begin
          cnt_d   = div_q;
          sclk_d  = 1'b0;
          rx_sh_d = rx_next;
          if (bit_q == 3'd7) begin
            mosi_d  = 1'b1;
            done_d  = 1'b1;
            rx_d    = rx_next;
            state_d = ST_IDLE;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            state_d = ST_LOW;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      rx_sh_q <= 8'h00;
      rx_q    <= 8'h00;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign sd_clk  = sclk_q;
  assign sd_mosi = mosi_q;
  assign sd_cs_n = cs_n_q;

  // Zero-wait-state read mux. It decodes address only, so unused bits read as zero.
  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      A_DATA:   bus.readdata[7:0]       = rx_q;
      A_STATUS: bus.readdata[3:0]       = {ovr_q, cs_n_q, done_q, busy};
      A_DIV:    bus.readdata[DIV_W-1:0] = div_q;
      default:  bus.readdata            = '0;
    endcase
  end

endmodule

// File: tb/tb_de2_115_sopc_sd_spi.sv
// Self-checking bench for de2_115_sopc_sd_spi: directed transfers with a half-period-level reference model.
// The bench includes a loopback mode and a simple mode-0 card that answers with a fixed byte.
module tb_de2_115_sopc_sd_spi;

  logic clk = 1'b0;
  logic reset_n;
  logic sd_clk, sd_mosi, sd_cs_n, sd_miso;

  logic       loopback  = 1'b1;
  logic [7:0] card_sr   = 8'hFF;
  logic [7:0] card_byte = 8'hFF;
  logic       cmp_en    = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  int          runs [32];
  int          n_runs;
  logic [31:0] rd;
  int          busy_n, pulses;
  logic [7:0]  pat;

  de2_115_sopc_sd_spi_if bus ();

  de2_115_sopc_sd_spi #(.DIV_W(8), .DEFAULT_DIV(124)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .sd_clk  (sd_clk),
    .sd_mosi (sd_mosi),
    .sd_cs_n (sd_cs_n),
    .sd_miso (sd_miso)
  );

  always #5 clk = ~clk;

  // The card presents its MSB before the first rise and moves to the next bit on each falling sd_clk.
  assign sd_miso = loopback ? sd_mosi : card_sr[7];
  always @(negedge sd_clk) card_sr = {card_sr[6:0], 1'b1};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, wanted 0x%0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: a transfer is 16 half-periods, and each half-period lasts (DIV at its start)+1 cycles.
  // MOSI carries bit 7-half/2, and the received byte is whatever the far end was sending.
  bit         m_active, m_was_active, m_set_done;
  int         m_half, m_left, m_div;
  logic [7:0] m_tx, m_src, m_rx;
  logic       m_done, m_ovr, m_cs_n;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_half = 0; m_left = 0; m_div = 124;
      m_tx = 0; m_src = 0; m_rx = 0; m_done = 0; m_ovr = 0; m_cs_n = 1;
    end else begin
      m_was_active = m_active;
      m_set_done   = 0;
      if (m_active) begin
        m_left--;
        if (m_left == 0) begin
          m_half++;
          if (m_half == 16) begin
            m_active = 0; m_done = 1; m_set_done = 1; m_rx = m_src;
          end else begin
            m_left = m_div + 1;
          end
        end
      end
      if (bus.chipselect && !bus.read_n && bus.address == 2'd0 && !m_set_done) m_done = 0;
      if (bus.chipselect && !bus.write_n) begin
        case (bus.address)
          2'd0: begin
            if (m_was_active) m_ovr = 1;
            else begin
              m_active = 1; m_half = 0; m_left = m_div + 1; m_done = 0;
              m_tx  = bus.writedata[7:0];
              m_src = loopback ? bus.writedata[7:0] : card_byte;
            end
          end
          2'd1: begin
            m_cs_n = bus.writedata[2];
            if (bus.writedata[3]) m_ovr = 0;
          end
          2'd2: m_div = int'(bus.writedata[7:0]);
          default: ;
        endcase
      end
    end
  end

  function automatic logic exp_mosi();
    if (!m_active) return 1'b1;
    return m_tx[7 - m_half / 2];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("pins", {29'b0, sd_clk, sd_mosi, sd_cs_n},
            {29'b0, (m_active && m_half[0]), exp_mosi(), m_cs_n});
      if (bus.chipselect && !bus.read_n && bus.address == 2'd1)
        check("status", bus.readdata, {28'b0, m_ovr, m_cs_n, m_done, m_active});
    end
  end

  task automatic idle_bus();
    bus.chipselect = 1'b1; bus.read_n = 1'b0; bus.write_n = 1'b1;
    bus.address = 2'd1; bus.writedata = '0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.read_n = 1'b1; bus.write_n = 1'b0;
    @(posedge clk); #1;
    idle_bus();
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.address = a; bus.read_n = 1'b0; bus.write_n = 1'b1;
    @(negedge clk);
    d = bus.readdata;
    @(posedge clk); #1;
    idle_bus();
  endtask

  // Starts a transfer and then samples every cycle until busy drops.
  // An optional extra write is accepted mid_at+2 cycles after the start.
  task automatic run_xfer(input logic [7:0] tx, input int mid_at, input logic [1:0] mid_a,
                          input logic [31:0] mid_d);
    int   c;
    int   len;
    logic prev, cur, b;
    bit   fin;
    busy_n = 0; pulses = 0; pat = 8'h00; n_runs = 0;
    prev = 1'b0; cur = 1'b0; len = 0; c = 0; fin = 0;
    bus_write(2'd0, {24'b0, tx});
    while (!fin) begin
      @(negedge clk);
      b = (bus.address == 2'd1 && !bus.read_n) ? bus.readdata[0] : 1'b1;
      if (!b) fin = 1;
      else begin
        busy_n++;
        if (sd_clk && !prev) begin pulses++; pat = {pat[6:0], sd_mosi}; end
        if (sd_clk == cur) len++;
        else begin
          if (n_runs < 32) runs[n_runs] = len;
          n_runs++; cur = sd_clk; len = 1;
        end
        prev = sd_clk;
        if (mid_at >= 0 && c == mid_at) begin
          @(posedge clk); #1;
          bus.address = mid_a; bus.writedata = mid_d; bus.read_n = 1'b1; bus.write_n = 1'b0;
        end else if (mid_at >= 0 && c == mid_at + 1) begin
          @(posedge clk); #1;
          idle_bus();
        end
        c++;
        if (c > 4000) begin check("xfer_timeout", c, 0); fin = 1; end
      end
    end
    if (n_runs < 32) runs[n_runs] = len;
    n_runs++;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle_bus();
    repeat (3) @(posedge clk);
    #1 cmp_en = 1'b1;

    // Reset values.
    @(negedge clk);
    check("rst_pins", {29'b0, sd_clk, sd_mosi, sd_cs_n}, 32'h3);
    @(posedge clk); #1 reset_n = 1'b1;
    bus_read(2'd2, rd); check("rst_div", rd, 32'd124);
    bus_read(2'd1, rd); check("rst_status", rd, 32'h4);
    bus_read(2'd0, rd); check("rst_data", rd, 32'h0);

    // Loopback of 0xA5 with DIV=2.
    loopback = 1'b1;
    bus_write(2'd2, 32'd2);
    bus_write(2'd1, 32'h0);
    run_xfer(8'hA5, -1, 2'd0, 32'h0);
    check("lb_busy_len", busy_n, 48);
    check("lb_pulses", pulses, 8);
    check("lb_mosi_pat", {24'b0, pat}, 32'hA5);
    check("lb_first_half", runs[0], 3);
    check("lb_last_half", runs[15], 3);
    bus_read(2'd1, rd); check("lb_status_done", rd, 32'h2);
    bus_read(2'd0, rd); check("lb_data", rd, 32'hA5);
    bus_read(2'd1, rd); check("lb_done_cleared", rd, 32'h0);

    // The card answers 0x3C while the bench sends 0xFF with DIV=4.
    bus_write(2'd2, 32'd4);
    loopback = 1'b0; card_byte = 8'h3C; card_sr = 8'h3C;
    run_xfer(8'hFF, -1, 2'd0, 32'h0);
    check("card_busy_len", busy_n, 80);
    check("card_mosi_pat", {24'b0, pat}, 32'hFF);
    check("card_half", runs[3], 5);
    bus_read(2'd0, rd); check("card_data", rd, 32'h3C);

    // A second DATA write 10 cycles into a transfer produces an overrun.
    loopback = 1'b1;
    bus_write(2'd2, 32'd2);
    run_xfer(8'h11, 8, 2'd0, 32'h22);
    check("ovr_busy_len", busy_n, 48);
    check("ovr_mosi_pat", {24'b0, pat}, 32'h11);
    bus_read(2'd1, rd); check("ovr_status", rd, 32'hA);
    bus_write(2'd1, 32'h8);
    bus_read(2'd1, rd); check("ovr_cleared", rd, 32'h2);
    bus_read(2'd0, rd); check("ovr_data", rd, 32'h11);

    // DIV changes from 2 to 5 during bit 3. The write is accepted in half-period 6, so that half-period keeps 3 cycles.
    run_xfer(8'h5A, 17, 2'd2, 32'd5);
    check("div_busy_len", busy_n, 75);
    check("div_half_count", n_runs, 16);
    check("div_half6", runs[6], 3);
    check("div_half7", runs[7], 6);
    check("div_half15", runs[15], 6);
    check("div_mosi_pat", {24'b0, pat}, 32'h5A);
    bus_read(2'd0, rd); check("div_data", rd, 32'h5A);
    bus_read(2'd2, rd); check("div_reg", rd, 32'd5);

    // Reset during bit 4 aborts the transfer, and a fresh transfer of 0x81 then completes normally.
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h96);
    repeat (25) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("abort_pins", {29'b0, sd_clk, sd_mosi, sd_cs_n}, 32'h3);
    @(posedge clk); #1;
    bus_read(2'd1, rd); check("abort_status", rd, 32'h4);
    bus_read(2'd0, rd); check("abort_rx", rd, 32'h0);
    bus_read(2'd2, rd); check("abort_div", rd, 32'd124);
    reset_n = 1'b1;
    @(posedge clk); #1;
    bus_write(2'd2, 32'd2);
    bus_write(2'd1, 32'h0);
    run_xfer(8'h81, -1, 2'd0, 32'h0);
    check("post_busy_len", busy_n, 48);
    check("post_mosi_pat", {24'b0, pat}, 32'h81);
    bus_read(2'd0, rd); check("post_data", rd, 32'h81);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
